// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one 6-bit ripple adder between N_REQ requesters.
// Optional `SAT_ADD_EN clamps signed-overflow results to +31 / -32.

module ripple_adder (
  input  logic [5:0] a,
  input  logic [5:0] b,
  input  logic       cin,
  output logic [5:0] sum,
  output logic       cout
);
  logic [6:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < 6; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[6];
endmodule

module adder_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [6*N_REQ-1:0] req_a,
  input  logic [6*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [5:0]         rsp_sum,
  output logic               rsp_cout,
  output logic               rsp_ovf,
  output logic               busy
);
  localparam int unsigned NR = N_REQ;
  localparam int          IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;

  state_t            state, state_nx;
  logic [ID_W-1:0]   ptr, ptr_nx, grant;
  logic              found;
  logic [5:0]        op_a, op_b;
  logic [ID_W-1:0]   op_id;
  logic [5:0]        raw_sum, sum_res;
  logic              raw_cout, ovf;
  logic [5:0]        a_arr [N_REQ];
  logic [5:0]        b_arr [N_REQ];
  int unsigned       ptr_i, idx, nxt;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[6*g +: 6];
    assign b_arr[g] = req_b[6*g +: 6];
  end

  // Rotating priority search; an out-of-range pointer restarts the search at 0.
  always_comb begin
    ptr_i = 32'(ptr);
    if (ptr_i > NR - 1) ptr_i = 0;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = ptr_i + k;
      if (idx >= NR) idx = idx - NR;
      if (!found && req_valid[idx[IW-1:0]]) begin
        found = 1'b1;
        grant = idx[ID_W-1:0];
      end
    end
    nxt = 32'(grant) + 1;
    if (nxt >= NR) nxt = 0;
    ptr_nx = nxt[ID_W-1:0];
  end

  ripple_adder u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (1'b0),
    .sum  (raw_sum),
    .cout (raw_cout)
  );

  always_comb begin
    ovf = (op_a[5] == op_b[5]) && (raw_sum[5] != op_a[5]);
`ifdef SAT_ADD_EN
    sum_res = ovf ? (op_a[5] ? 6'b100000 : 6'b011111) : raw_sum;
`else
    sum_res = raw_sum;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = ADD;
      ADD:     state_nx = HOLD;
      HOLD:    if (rsp_valid && rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = (state != IDLE);
    if (state == IDLE && found) req_ready[grant[IW-1:0]] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          op_a  <= a_arr[grant[IW-1:0]];
          op_b  <= b_arr[grant[IW-1:0]];
          op_id <= grant;
          ptr   <= ptr_nx;
        end
        ADD: begin
          rsp_sum   <= sum_res;
          rsp_cout  <= raw_cout;
          rsp_ovf   <= ovf;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
        end
        HOLD: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed and randomized bench for adder_share_arbiter with a transaction-level model.
module tb_adder_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [23:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [5:0]  rsp_sum;
  logic        rsp_cout, rsp_ovf, busy;

  logic [5:0]  ta [4];
  logic [5:0]  tb [4];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_a = {ta[3], ta[2], ta[1], ta[0]};
    req_b = {tb[3], tb[2], tb[1], tb[0]};
  end

  adder_share_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [7:0] model_add(input logic [5:0] a, input logic [5:0] b);
    int u, s;
    logic [5:0] r;
    u = int'(a) + int'(b);
    s = int'($signed(a)) + int'($signed(b));
    r = 6'(u % 64);
`ifdef SAT_ADD_EN
    if (s > 31) r = 6'd31;
    else if (s < -32) r = 6'b100000;
`endif
    return {(s > 31 || s < -32), (u > 63), r};
  endfunction

  task automatic single(input int i, input logic [5:0] a, input logic [5:0] b,
                        input logic [5:0] es, input logic ec, input logic eo);
    @(negedge clk);
    req_valid = 4'b0001 << i;
    ta[i[1:0]] = a;
    tb[i[1:0]] = b;
    #1 chk("single_grant", 32'(req_ready), 32'(4'b0001 << i));
    @(negedge clk);
    req_valid = '0;
    #1 chk("single_add_busy", 32'(busy), 1);
    chk("single_add_rspv", 32'(rsp_valid), 0);
    chk("single_add_ready", 32'(req_ready), 0);
    @(negedge clk);
    #1 chk("single_rspv", 32'(rsp_valid), 1);
    chk("single_id", 32'(rsp_id), 32'(i));
    chk("single_sum", 32'(rsp_sum), 32'(es));
    chk("single_cout", 32'(rsp_cout), 32'(ec));
    chk("single_ovf", 32'(rsp_ovf), 32'(eo));
    @(negedge clk);
    #1 chk("single_idle_busy", 32'(busy), 0);
    chk("single_idle_rspv", 32'(rsp_valid), 0);
  endtask

  initial begin
    int        ord [6] = '{0, 1, 2, 3, 0, 1};
    int        mptr, age, g, e_id;
    bit        pend;
    logic [3:0] v, gseen, e_rr;
    logic [7:0] e_res;

    rst = 1'b1; rsp_ready = 1'b1; req_valid = '0;
    for (int i = 0; i < 4; i++) begin ta[i[1:0]] = '0; tb[i[1:0]] = '0; end
    @(negedge clk);
    #1 chk("rst_rspv", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_sum", 32'({rsp_id, rsp_cout, rsp_ovf, rsp_sum}), 0);
    rst = 1'b0;

    single(0, 6'd5, 6'd7, 6'd12, 1'b0, 1'b0);
    single(1, 6'd63, 6'd1, 6'd0, 1'b1, 1'b0);
`ifdef SAT_ADD_EN
    single(2, 6'd31, 6'd1, 6'd31, 1'b0, 1'b1);
`else
    single(2, 6'd31, 6'd1, 6'b100000, 1'b0, 1'b1);
`endif

    // Backpressure: pointer now 3, requester 3 only
    for (int i = 0; i < 3; i++) begin ta[i[1:0]] = 6'(i + 1); tb[i[1:0]] = 6'd10; end
    @(negedge clk);
    req_valid = 4'b1000; ta[3] = 6'd40; tb[3] = 6'd30; rsp_ready = 1'b0;
    #1 chk("bp_grant", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = 4'b1111; ta[3] = 6'd4; tb[3] = 6'd10;
    #1 chk("bp_add_ready", 32'(req_ready), 0);
    @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      #1 chk("bp_rspv", 32'(rsp_valid), 1);
      chk("bp_sum", 32'(rsp_sum), 6);
      chk("bp_flags", 32'({rsp_id, rsp_cout, rsp_ovf}), 32'({2'd3, 1'b1, 1'b0}));
      chk("bp_busy", 32'(busy), 1);
      chk("bp_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1 chk("bp_release_busy", 32'(busy), 0);
    chk("bp_release_rspv", 32'(rsp_valid), 0);

    // Round robin with all four requesters continuously valid
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_grant", 32'(req_ready), 32'(4'b0001 << ord[k]));
      @(negedge clk);
      @(negedge clk);
      #1 chk("rr_id", 32'(rsp_id), 32'(ord[k]));
      chk("rr_sum", 32'(rsp_sum), 32'(ord[k] + 11));
      @(negedge clk);
    end

    // Reset during ADD: pointer would be 3 afterwards without the reset
    req_valid = 4'b0100;
    #1 chk("rst_mid_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = 4'b0000;
    #2 rst = 1'b1;
    #1 chk("rst_mid_rspv", 32'(rsp_valid), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_regs", 32'({rsp_id, rsp_cout, rsp_ovf, rsp_sum}), 0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b1010;
    #1 chk("rst_mid_first_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);

    // Randomized traffic against the transaction model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mptr = 0; pend = 0; age = 0; e_id = 0; e_res = '0; v = '0; gseen = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (gseen[i[1:0]] || !v[i[1:0]]) begin
          if (gseen[i[1:0]] || $urandom_range(0, 2) == 0) begin
            v[i[1:0]]  = ($urandom_range(0, 3) != 0);
            ta[i[1:0]] = 6'($urandom_range(0, 63));
            tb[i[1:0]] = 6'($urandom_range(0, 63));
          end
        end else if ($urandom_range(0, 15) == 0) begin
          v[i[1:0]] = 1'b0;
        end
      end
      req_valid = v;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      e_rr = '0; g = -1;
      if (!pend) begin
        for (int k = 0; k < 4; k++) begin
          int idx;
          idx = (mptr + k) % 4;
          if (g < 0 && v[idx[1:0]]) g = idx;
        end
        if (g >= 0) e_rr = 4'b0001 << g;
      end
      chk("rnd_ready", 32'(req_ready), 32'(e_rr));
      chk("rnd_busy", 32'(busy), 32'(pend));
      chk("rnd_rspv", 32'(rsp_valid), 32'(pend && age >= 1));
      if (pend && age >= 1) begin
        chk("rnd_id", 32'(rsp_id), 32'(e_id));
        chk("rnd_res", 32'({rsp_ovf, rsp_cout, rsp_sum}), 32'(e_res));
      end
      if (!pend) begin
        if (g >= 0) begin
          pend = 1; age = 0; e_id = g;
          e_res = model_add(ta[g[1:0]], tb[g[1:0]]);
          mptr = (g + 1) % 4;
        end
      end else if (age >= 1 && rsp_ready) begin
        pend = 0;
      end else begin
        age++;
      end
      gseen = e_rr;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
